// File: rtl/fetch_decode_if.sv
// Fetch/decode handshake bundle: hazard-unit controls, instruction memory port
// and the IF/ID outputs that feed decode.
interface fetch_decode_if;
   logic        stallF;
   logic        stallD;
   logic        pcsrcD;
   logic        jumpD;
   logic        imem_rdy;
   logic [31:0] instrF;
   logic [31:0] pcF;
   logic [31:0] instrD;
   logic [31:0] pcplus4D;
   logic        validD;
   logic        flushD;

   modport master (
      output stallF, stallD, pcsrcD, jumpD, imem_rdy, instrF,
      input  pcF, instrD, pcplus4D, validD, flushD
   );

   modport slave (
      input  stallF, stallD, pcsrcD, jumpD, imem_rdy, instrF,
      output pcF, instrD, pcplus4D, validD, flushD
   );
endinterface

// File: rtl/fetch_decode_stage.sv
// MIPS fetch stage plus IF/ID pipeline register with branch/jump redirect.
// Optional macro FETCH_PERF_EN adds saturating stall/redirect/imem-wait counters.
module fetch_decode_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   fetch_decode_if.slave bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_redirects,
   output logic [31:0] perf_imem_waits
`endif
);

   logic [31:0] r_pcF;
   logic [31:0] r_instrD;
   logic [31:0] r_pcplus4D;
   logic        r_validD;

   logic [31:0] w_pcplus4F;
   logic [31:0] w_branch_ofs;
   logic [31:0] w_pcbranchD;
   logic [31:0] w_pcjumpD;
   logic [31:0] w_target;
   logic        w_redirect;

   assign w_pcplus4F   = r_pcF + 32'd4;
   assign w_branch_ofs = {{14{r_instrD[15]}}, r_instrD[15:0], 2'b00};
   assign w_pcbranchD  = r_pcplus4D + w_branch_ofs;
   assign w_pcjumpD    = {r_pcplus4D[31:28], r_instrD[25:0], 2'b00};

   // Decode controls are only meaningful for a real, non-stalled instruction.
   assign w_redirect = r_validD & ~bus.stallD & (bus.pcsrcD | bus.jumpD);
   assign w_target   = bus.jumpD ? w_pcjumpD : w_pcbranchD;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pcF <= RESET_PC;
      end else if (bus.stallF) begin
         r_pcF <= r_pcF;
      end else if (w_redirect) begin
         r_pcF <= w_target;
      end else if (bus.imem_rdy) begin
         r_pcF <= w_pcplus4F;
      end
   end

   // Branch-shadow fetch is squashed: no delay slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_instrD   <= NOP_INSTR;
         r_pcplus4D <= 32'd0;
         r_validD   <= 1'b0;
      end else if (bus.stallD) begin
         r_instrD   <= r_instrD;
         r_pcplus4D <= r_pcplus4D;
         r_validD   <= r_validD;
      end else if (w_redirect) begin
         r_instrD   <= NOP_INSTR;
         r_pcplus4D <= 32'd0;
         r_validD   <= 1'b0;
      end else if (!bus.imem_rdy) begin
         r_instrD   <= NOP_INSTR;
         r_validD   <= 1'b0;
      end else begin
         r_instrD   <= bus.instrF;
         r_pcplus4D <= w_pcplus4F;
         r_validD   <= 1'b1;
      end
   end

   assign bus.pcF      = r_pcF;
   assign bus.instrD   = r_instrD;
   assign bus.pcplus4D = r_pcplus4D;
   assign bus.validD   = r_validD;
   assign bus.flushD   = w_redirect;

`ifdef FETCH_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_redir;
   logic [31:0] r_perf_wait;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_perf_stall <= 32'd0;
         r_perf_redir <= 32'd0;
         r_perf_wait  <= 32'd0;
      end else begin
         if (bus.stallF)
            r_perf_stall <= sat_inc(r_perf_stall);
         if (w_redirect)
            r_perf_redir <= sat_inc(r_perf_redir);
         if (!bus.imem_rdy && !bus.stallF && !w_redirect)
            r_perf_wait <= sat_inc(r_perf_wait);
      end
   end

   assign perf_stall_cycles = r_perf_stall;
   assign perf_redirects    = r_perf_redir;
   assign perf_imem_waits   = r_perf_wait;
`endif

endmodule
